// File: rtl/vector_op.sv
// vector_op: streams N element pairs from the x/y memories through an
// elementwise operator (add, sub, signed max, signed min) into the z memory.
// One read per cycle; the write for element k lands one cycle later, once the
// synchronous memory data is available.
// Optional build macro: VECTOR_OP_SAT_EN -- saturating add/sub (default wraps).
module vector_op #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int VECTOR_SIZE = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [1:0]            op,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] y_addr,
  input  logic [DATA_WIDTH-1:0] x_dout,
  input  logic [DATA_WIDTH-1:0] y_dout,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [DATA_WIDTH-1:0] z_din,
  output logic                  z_wr_en
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MAX = 2'd2,
    OP_MIN = 2'd3
  } op_e;

  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(VECTOR_SIZE);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic                  vld_q, vld_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH:0]   len_eff;
  logic                  last_addr;
  logic [DATA_WIDTH-1:0] add_r, sub_r, res;

  // State and datapath registers; reset aborts any run without a final write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      len_q   <= '0;
      cnt_q   <= '0;
      wa_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  // Length clamp and last-address detect.
  always_comb begin
    len_eff   = (len > LEN_MAX) ? LEN_MAX : len;
    last_addr = (({1'b0, cnt_q} + (ADDR_WIDTH+1)'(1)) == len_q);
  end

  // Next-state, read address generation and write-pipeline valid.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wa_d    = '0;
    vld_d   = 1'b0;
    done_d  = done_q;
    x_addr  = '0;
    y_addr  = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          op_d    = op_e'(op);
          len_d   = len_eff;
          done_d  = 1'b0;
          state_d = (len_eff == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        x_addr = cnt_q;
        y_addr = cnt_q;
        vld_d  = 1'b1;
        wa_d   = cnt_q;
        if (last_addr) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef VECTOR_OP_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic [DATA_WIDTH:0] sum_x, dif_x;

  // Saturating add/sub: overflow shows as the two top bits of the extended result differing.
  always_comb begin
    sum_x = {x_dout[DATA_WIDTH-1], x_dout} + {y_dout[DATA_WIDTH-1], y_dout};
    dif_x = {x_dout[DATA_WIDTH-1], x_dout} - {y_dout[DATA_WIDTH-1], y_dout};
    if (sum_x[DATA_WIDTH] != sum_x[DATA_WIDTH-1])
      add_r = sum_x[DATA_WIDTH] ? SMIN : SMAX;
    else
      add_r = sum_x[DATA_WIDTH-1:0];
    if (dif_x[DATA_WIDTH] != dif_x[DATA_WIDTH-1])
      sub_r = dif_x[DATA_WIDTH] ? SMIN : SMAX;
    else
      sub_r = dif_x[DATA_WIDTH-1:0];
  end
`else
  // Wrapping add/sub modulo 2^DATA_WIDTH.
  always_comb begin
    add_r = x_dout + y_dout;
    sub_r = x_dout - y_dout;
  end
`endif

  // Operator select; write port is held at zero whenever no write is issued.
  always_comb begin
    case (op_q)
      OP_ADD:  res = add_r;
      OP_SUB:  res = sub_r;
      OP_MAX:  res = ($signed(x_dout) > $signed(y_dout)) ? x_dout : y_dout;
      default: res = ($signed(x_dout) < $signed(y_dout)) ? x_dout : y_dout;
    endcase
    z_wr_en = vld_q;
    z_addr  = vld_q ? wa_q : '0;
    z_din   = vld_q ? res  : '0;
    busy    = (state_q == RUN) || (state_q == DRAIN);
    done    = done_q;
  end

endmodule
